pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Consumer side of the hazard/stall interface. Takes the load-use stall request from the
//   hazard unit, the data-memory busy flag and the EX-stage branch-taken flag. Drives the
//   pipeline-register write enables, the IF/ID flush and the ID/EX bubble. Keeps stall and
//   flush performance counters and a watchdog on memory freezes.
// PARAMETERS
//   CNT_W           16   width of stall_cycles / flush_count (saturating)
//   FREEZE_TIMEOUT  64   consecutive mem_busy cycles that set freeze_err (>=1)
// PORTS
//   clk           in   1      rising-edge clock; single clock domain
//   rst           in   1      asynchronous, active-high reset
//   stall_req     in   1      load-use stall request from hazard unit (combinational)
//   mem_busy      in   1      data memory not ready; whole pipeline must hold
//   branch_taken  in   1      EX resolved a taken branch/jump; younger stages are wrong-path
//   pc_we         out  1      PC write enable
//   if_id_we      out  1      IF/ID register write enable
//   if_id_flush   out  1      IF/ID register loads NOP (32'd0)
//   id_ex_bubble  out  1      ID/EX register loads NOP instead of decoded inst
//   ex_mem_we     out  1      EX/MEM register write enable
//   mem_wb_we     out  1      MEM/WB register write enable
//   freeze_err    out  1      sticky: a freeze lasted >= FREEZE_TIMEOUT cycles
//   stall_cycles  out  CNT_W  cycles with pc_we=0 outside reset, saturating
//   flush_count   out  CNT_W  number of branch-flush cycles, saturating
// BEHAVIOUR
//   - States: RUN, LU (one cycle after a load-use bubble), FREEZE (mem_busy seen last cycle).
//   - Reset (rst=1, async): state=RUN, counters=0, freeze_err=0, watchdog=0.
//     While rst=1 every output is 0: all *_we, if_id_flush and id_ex_bubble.
//   - Outputs are combinational from the current inputs and the registered state.
//     Priority each cycle: mem_busy > branch_taken > stall_req (masked in LU) > normal.
//   - mem_busy=1: pc_we=if_id_we=ex_mem_we=mem_wb_we=0, if_id_flush=id_ex_bubble=0.
//     Next state is FREEZE. stall_cycles+1. Watchdog +1, saturating at FREEZE_TIMEOUT.
//   - branch_taken=1 (mem_busy=0): all we=1, if_id_flush=1, id_ex_bubble=1.
//     Next state is RUN. flush_count+1. A simultaneous stall_req is dropped.
//   - stall_req=1, state!=LU, no higher-priority input: pc_we=0 and if_id_we=0;
//     id_ex_bubble=1; ex_mem_we=mem_wb_we=1. Next state is LU. stall_cycles+1.
//   - State LU: stall_req is ignored for this one cycle, so one load-use gives exactly one
//     bubble. Outputs are normal unless mem_busy or branch_taken is set.
//   - Normal: all we=1, flush=bubble=0. Next state is RUN.
//   - FREEZE with mem_busy=0: handled like RUN (no LU mask). A stall_req held through the
//     freeze is served in the first unfrozen cycle.
//   - Watchdog clears on any cycle with mem_busy=0. freeze_err is set on the edge at which
//     the watchdog reaches FREEZE_TIMEOUT, and only reset clears it.
//   - Counters saturate at 2^CNT_W-1 and never wrap. Reset mid-freeze or mid-LU goes
//     straight to RUN and clears the mask.
// TESTING
//   1. rst=1 with random inputs -> every output 0, both counters 0; rst released -> pc_we=1 next cycle.
//   2. stall_req held 3 cycles -> c0 pc_we=0,if_id_we=0,id_ex_bubble=1; c1 all we=1 (masked);
//      c2 stall again; stall_cycles=2.
//   3. mem_busy 5 cycles with stall_req=1,branch_taken=1 -> 5 cycles all we=0, no flush;
//      c5 flush (branch wins); stall_cycles=5, flush_count=1.
//   4. branch_taken and stall_req in the same RUN cycle -> if_id_flush=1, id_ex_bubble=1, pc_we=1;
//      next cycle stall_req=1 is served (no LU mask).
//   5. FREEZE_TIMEOUT=64, mem_busy for 63 cycles -> freeze_err=0; drop 1 cycle, then 64 cycles ->
//      freeze_err=1 after 64th edge, stays 1 after mem_busy=0.
//   6. CNT_W=4, 20 load-use stalls spaced 2 apart -> stall_cycles=15, flush_count=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard-unit stall requests, data-memory
// busy and EX branch-taken into pipeline-register write enables, IF/ID flush and
// ID/EX bubble, and keeps stall/flush counters plus a memory-freeze watchdog.
module pipe_stall_ctrl #(
    parameter int CNT_W          = 16,
    parameter int FREEZE_TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_req,
    input  logic             i_mem_busy,
    input  logic             i_branch_taken,
    output logic             o_pc_we,
    output logic             o_if_id_we,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_we,
    output logic             o_mem_wb_we,
    output logic             o_freeze_err,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int              WD_W     = $clog2(FREEZE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(FREEZE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // LU masks stall_req for one cycle after a served load-use; FREEZE marks a held pipeline.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU     = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WD_W-1:0]  r_watchdog;
    logic             r_freeze_err;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    state_t           w_next_state;
    logic             w_pc_we;
    logic             w_if_id_we;
    logic             w_if_id_flush;
    logic             w_id_ex_bubble;
    logic             w_ex_mem_we;
    logic             w_mem_wb_we;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic [WD_W-1:0]  w_watchdog_next;

    // Priority decode: mem_busy > branch_taken > unmasked stall_req > normal flow.
    always_comb begin
        w_next_state   = ST_RUN;
        w_pc_we        = 1'b1;
        w_if_id_we     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_we    = 1'b1;
        w_mem_wb_we    = 1'b1;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        if (i_rst) begin
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_ex_mem_we = 1'b0;
            w_mem_wb_we = 1'b0;
        end else if (i_mem_busy) begin
            w_next_state = ST_FREEZE;
            w_pc_we      = 1'b0;
            w_if_id_we   = 1'b0;
            w_ex_mem_we  = 1'b0;
            w_mem_wb_we  = 1'b0;
            w_stall_inc  = 1'b1;
        end else if (i_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_flush_inc    = 1'b1;
        end else if (i_stall_req && (r_state != ST_LU)) begin
            w_next_state   = ST_LU;
            w_pc_we        = 1'b0;
            w_if_id_we     = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_stall_inc    = 1'b1;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // Watchdog counts consecutive busy cycles, saturating at the timeout; any idle cycle clears it.
    always_comb begin
        w_watchdog_next = '0;
        if (i_mem_busy) begin
            if (r_watchdog == WD_LIMIT) begin
                w_watchdog_next = WD_LIMIT;
            end else begin
                w_watchdog_next = r_watchdog + WD_ONE;
            end
        end else begin
            w_watchdog_next = '0;
        end
    end

    // State, watchdog, sticky freeze error and saturating performance counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_RUN;
            r_watchdog     <= '0;
            r_freeze_err   <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_watchdog   <= w_watchdog_next;
            r_freeze_err <= r_freeze_err | (w_watchdog_next == WD_LIMIT);
            if (w_stall_inc && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign o_pc_we        = w_pc_we;
    assign o_if_id_we     = w_if_id_we;
    assign o_if_id_flush  = w_if_id_flush;
    assign o_id_ex_bubble = w_id_ex_bubble;
    assign o_ex_mem_we    = w_ex_mem_we;
    assign o_mem_wb_we    = w_mem_wb_we;
    assign o_freeze_err   = r_freeze_err;
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (16-bit and 4-bit counters) share the
// stimulus; a rule-level model is compared on every falling edge, and directed
// scenarios add literal expectations.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_req = 1'b0;
    logic mem_busy = 1'b0;
    logic branch_taken = 1'b0;

    logic a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_bubble, a_ex_mem_we, a_mem_wb_we, a_freeze_err;
    logic [15:0] a_stall_cycles, a_flush_count;
    logic b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_bubble, b_ex_mem_we, b_mem_wb_we, b_freeze_err;
    logic [3:0] b_stall_cycles, b_flush_count;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_mask = 1'b0;
    int m_wd = 0;
    bit m_err = 1'b0;
    int m_sc16 = 0, m_fc16 = 0, m_sc4 = 0, m_fc4 = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(16), .FREEZE_TIMEOUT(64)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_stall_req(stall_req), .i_mem_busy(mem_busy),
        .i_branch_taken(branch_taken), .o_pc_we(a_pc_we), .o_if_id_we(a_if_id_we),
        .o_if_id_flush(a_if_id_flush), .o_id_ex_bubble(a_id_ex_bubble),
        .o_ex_mem_we(a_ex_mem_we), .o_mem_wb_we(a_mem_wb_we), .o_freeze_err(a_freeze_err),
        .o_stall_cycles(a_stall_cycles), .o_flush_count(a_flush_count)
    );

    pipe_stall_ctrl #(.CNT_W(4), .FREEZE_TIMEOUT(64)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stall_req(stall_req), .i_mem_busy(mem_busy),
        .i_branch_taken(branch_taken), .o_pc_we(b_pc_we), .o_if_id_we(b_if_id_we),
        .o_if_id_flush(b_if_id_flush), .o_id_ex_bubble(b_id_ex_bubble),
        .o_ex_mem_we(b_ex_mem_we), .o_mem_wb_we(b_mem_wb_we), .o_freeze_err(b_freeze_err),
        .o_stall_cycles(b_stall_cycles), .o_flush_count(b_flush_count)
    );

    function automatic void chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Expected control bits {pc, if_id, flush, bubble, ex_mem, mem_wb} from the priority rules.
    function automatic logic [5:0] exp_ctl();
        if (rst) return 6'b000000;
        if (mem_busy) return 6'b000000;
        if (branch_taken) return 6'b111111;
        if (stall_req && !m_mask) return 6'b000111;
        return 6'b110011;
    endfunction

    // Model update: mask is set only by a served load-use; watchdog counts consecutive busy cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mask <= 1'b0; m_wd <= 0; m_err <= 1'b0;
            m_sc16 <= 0; m_fc16 <= 0; m_sc4 <= 0; m_fc4 <= 0;
        end else if (mem_busy) begin
            m_mask <= 1'b0;
            m_wd <= sat_inc(m_wd, 64);
            if (m_wd + 1 >= 64) m_err <= 1'b1;
            m_sc16 <= sat_inc(m_sc16, 65535);
            m_sc4 <= sat_inc(m_sc4, 15);
        end else if (branch_taken) begin
            m_mask <= 1'b0; m_wd <= 0;
            m_fc16 <= sat_inc(m_fc16, 65535);
            m_fc4 <= sat_inc(m_fc4, 15);
        end else if (stall_req && !m_mask) begin
            m_mask <= 1'b1; m_wd <= 0;
            m_sc16 <= sat_inc(m_sc16, 65535);
            m_sc4 <= sat_inc(m_sc4, 15);
        end else begin
            m_mask <= 1'b0; m_wd <= 0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("ctl_a", {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_bubble, a_ex_mem_we, a_mem_wb_we}, exp_ctl());
        chk("ctl_b", {b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_bubble, b_ex_mem_we, b_mem_wb_we}, exp_ctl());
        chk("stall_a", a_stall_cycles, m_sc16);
        chk("flush_a", a_flush_count, m_fc16);
        chk("stall_b", b_stall_cycles, m_sc4);
        chk("flush_b", b_flush_count, m_fc4);
        chk("ferr_a", a_freeze_err, m_err);
        chk("ferr_b", b_freeze_err, m_err);
    end

    task automatic cyc(input bit sr, input bit mb, input bit bt);
        @(posedge clk);
        #1;
        stall_req = sr; mem_busy = mb; branch_taken = bt;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; stall_req = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
    endtask

    initial begin
        // 1: reset with random inputs
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("rst_pc_we", a_pc_we, 0);
            chk("rst_flush", a_if_id_flush, 0);
            chk("rst_bubble", a_id_ex_bubble, 0);
            chk("rst_stall_cnt", a_stall_cycles, 0);
            chk("rst_flush_cnt", a_flush_count, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; stall_req = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
        #2;
        chk("post_rst_pc_we", a_pc_we, 1);

        // 2: load-use held three cycles
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        chk("lu_c0_pc_we", a_pc_we, 0);
        chk("lu_c0_if_id_we", a_if_id_we, 0);
        chk("lu_c0_bubble", a_id_ex_bubble, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("lu_c1_pc_we", a_pc_we, 1);
        chk("lu_c1_bubble", a_id_ex_bubble, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("lu_c2_pc_we", a_pc_we, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("lu_stall_cnt", a_stall_cycles, 2);

        // 3: memory freeze beats branch and stall
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("frz_pc_we", a_pc_we, 0);
            chk("frz_mem_wb_we", a_mem_wb_we, 0);
            chk("frz_flush", a_if_id_flush, 0);
        end
        cyc(1'b1, 1'b0, 1'b1);
        chk("frz_end_flush", a_if_id_flush, 1);
        chk("frz_end_pc_we", a_pc_we, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("frz_stall_cnt", a_stall_cycles, 5);
        chk("frz_flush_cnt", a_flush_count, 1);

        // 4: branch drops a simultaneous stall, next stall served without mask
        do_reset();
        cyc(1'b1, 1'b0, 1'b1);
        chk("br_flush", a_if_id_flush, 1);
        chk("br_bubble", a_id_ex_bubble, 1);
        chk("br_pc_we", a_pc_we, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("br_next_pc_we", a_pc_we, 0);
        chk("br_next_bubble", a_id_ex_bubble, 1);
        cyc(1'b0, 1'b0, 1'b0);

        // 5: freeze watchdog
        do_reset();
        for (int i = 0; i < 63; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wd_63_err", a_freeze_err, 0);
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b0);
        chk("wd_63b_err", a_freeze_err, 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("wd_64_err", a_freeze_err, 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("wd_sticky_err", a_freeze_err, 1);

        // 6: counter saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("sat_stall_b", b_stall_cycles, 15);
        chk("sat_flush_b", b_flush_count, 0);
        chk("sat_stall_a", a_stall_cycles, 20);

        // random mix, including occasional resets
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 40) == 0);
            mem_busy = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            stall_req = ($urandom_range(0, 1) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
